// File: rtl/z16_pkg.sv
// Shared constants and state encoding for the Z16 register file.
package z16_pkg;

  localparam int Z16_DATA_W = 16;
  localparam int Z16_ADDR_W = 4;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/z16_regfile_clear_seq.sv
// Clear sequencer: walks every register entry to zero after reset or on request,
// then holds READY until the next clear request.
module z16_regfile_clear_seq
  import z16_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = Z16_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = RF_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RF_READY: begin
        if (i_clear) begin
          state_d   = RF_CLEAR;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  assign o_clr_we   = (state_q == RF_CLEAR);
  assign o_clr_addr = clr_idx_q;
  assign o_ready    = (state_q == RF_READY);

endmodule

// File: rtl/z16_regfile_mp.sv
// Multi-read-port register file: NUM_RD combinational reads, one synchronous write,
// optional hardwired zero entry and optional write-to-read bypass.
module z16_regfile_mp
  import z16_pkg::*;
#(
  parameter int DATA_W   = Z16_DATA_W,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = Z16_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  output logic                     o_ready,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic                     i_rd_wen,
  input  logic [DATA_W-1:0]        i_rd_data
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              port_we;
  logic              wr_is_zero;

  logic [DATA_W-1:0] mem_q [DEPTH];

  z16_regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (i_clear),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr),
    .o_ready    (ready)
  );

  assign wr_is_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign port_we    = ready && i_rd_wen && !i_rst && !wr_is_zero;

  // NOTE: the array has no reset branch; the clear walk defines every entry
  // instead, which keeps the storage a plain RAM-style structure.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (port_we) begin
      mem_q[i_rd_addr] <= i_rd_data;
    end
  end

  // Read lanes: zero entry beats bypass, bypass beats the stored value, and the
  // whole port is masked to zero while the walk is still running.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit;

    assign addr    = i_rs_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && ready && i_rd_wen && (i_rd_addr == addr);

    assign o_rs_data[k*DATA_W +: DATA_W] = (!ready || is_zero) ? '0 :
                                           hit                 ? i_rd_data :
                                                                 mem_q[addr];
  end

  assign o_ready = ready;

endmodule
